// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational imem address, IF/ID latch.
// Redirect beats stall, stall beats fetch disable, otherwise fetch sequentially.
module fetch_unit #(
    parameter int          ADDR_BITS = 5,
    parameter logic [31:0] NOP       = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_data,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc,
    output logic                 if_id_valid,
    output logic [31:0]          fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Redirect targets are word aligned, so the low target bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            if_id_instr_d = NOP;
            if_id_pc_d    = '0;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if (!fetch_en) begin
                if_id_instr_d = NOP;
                if_id_pc_d    = '0;
                if_id_valid_d = 1'b0;
            end else begin
                pc_d          = pc_q + 32'd4;
                if_id_instr_d = imem_data;
                if_id_pc_d    = pc_q;
                if_id_valid_d = 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= '0;
            if_id_instr_q <= NOP;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q[ADDR_BITS-1:0];
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized control checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int          AB  = 5;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [AB-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic [31:0]   fetch_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:(1<<AB)/4-1];
    assign imem_data = mem[imem_addr[AB-1:2]];

    // Reference state
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid;

    fetch_unit #(.ADDR_BITS(AB), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 0; m_cnt = 0;
    endfunction

    // One clock edge worth of the fetch rules, applied with the current inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else if (redirect) begin
            m_pc = redirect_pc & ~32'd3;
            m_instr = NOP; m_ipc = 0; m_valid = 0;
        end else if (stall) begin
        end else if (!fetch_en) begin
            m_instr = NOP; m_ipc = 0; m_valid = 0;
        end else begin
            m_instr = mem[(m_pc % (1 << AB)) / 4];
            m_ipc = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
            m_pc = m_pc + 4;
        end
        #1;
    endtask

    task automatic set_in(input logic en, input logic st, input logic rd, input logic [31:0] rpc);
        fetch_en = en; stall = st; redirect = rd; redirect_pc = rpc;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_in(1, 0, 0, 0);
        tick(); tick();
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr} !==
            {NOP, 32'd0, 1'b0, 32'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset: instr=%h pc=%h valid=%b cnt=%0d addr=%h expected NOP/0/0/0/0",
                     if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr);
        end
    endtask

    task automatic test_sequential();
        rst = 1'b0; set_in(1, 0, 0, 0);
        tick(); tick(); tick();
        checks++;
        if ({if_id_pc, if_id_instr, fetch_count, imem_addr} !== {32'd8, 32'h102, 32'd3, 5'd12}) begin
            errors++;
            $display("FAIL sequential: pc=%h instr=%h cnt=%0d addr=%h expected 8/102/3/0c",
                     if_id_pc, if_id_instr, fetch_count, imem_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_instr, s_pc, s_cnt;
        logic        s_valid;
        set_in(1, 0, 1, 32'h8); tick();
        set_in(1, 0, 0, 0); tick();
        redirect_pc = 32'h8; redirect = 1'b1; tick(); redirect = 1'b0;
        s_instr = if_id_instr; s_pc = if_id_pc; s_valid = if_id_valid; s_cnt = fetch_count;
        stall = 1'b1;
        tick(); tick();
        checks++;
        if ({imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count} !==
            {5'd8, s_instr, s_pc, s_valid, s_cnt} || fetch_count !== m_cnt) begin
            errors++;
            $display("FAIL stall_hold: addr=%h instr=%h pc=%h cnt=%0d expected 08/%h/%h/%0d",
                     imem_addr, if_id_instr, if_id_pc, fetch_count, s_instr, s_pc, s_cnt);
        end
        stall = 1'b0; tick();
        checks++;
        if ({if_id_pc, if_id_instr, if_id_valid, imem_addr, fetch_count} !==
            {32'd8, 32'h102, 1'b1, 5'd12, s_cnt + 32'd1}) begin
            errors++;
            $display("FAIL stall_resume: pc=%h instr=%h valid=%b addr=%h cnt=%0d expected 8/102/1/0c/%0d",
                     if_id_pc, if_id_instr, if_id_valid, imem_addr, fetch_count, s_cnt + 1);
        end
    endtask

    task automatic test_redirect_over_stall();
        set_in(1, 1, 1, 32'h1E); tick();
        checks++;
        if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {5'h1C, 1'b0, NOP, 32'd0}) begin
            errors++;
            $display("FAIL redirect_stall: addr=%h valid=%b instr=%h pc=%h expected 1c/0/13/0",
                     imem_addr, if_id_valid, if_id_instr, if_id_pc);
        end
        set_in(1, 0, 0, 0); tick();
        checks++;
        if ({if_id_pc, if_id_valid, if_id_instr} !== {32'h1C, 1'b1, 32'h107}) begin
            errors++;
            $display("FAIL redirect_follow: pc=%h valid=%b instr=%h expected 1c/1/107",
                     if_id_pc, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        set_in(1, 0, 1, 32'h1C); tick();
        set_in(1, 0, 0, 0); tick();
        checks++;
        if ({imem_addr, if_id_pc} !== {5'd0, 32'h1C}) begin
            errors++;
            $display("FAIL addr_wrap: addr=%h pc=%h expected 00/1c", imem_addr, if_id_pc);
        end
        tick();
        checks++;
        if ({if_id_pc, if_id_instr, imem_addr} !== {32'h20, 32'h100, 5'd4}) begin
            errors++;
            $display("FAIL addr_wrap_fetch: pc=%h instr=%h addr=%h expected 20/100/04",
                     if_id_pc, if_id_instr, imem_addr);
        end
        set_in(1, 0, 1, 32'hFFFFFFFF); tick();
        set_in(1, 0, 0, 0); tick(); tick();
        checks++;
        if ({if_id_pc, if_id_instr, imem_addr} !== {32'd0, 32'h100, 5'd4}) begin
            errors++;
            $display("FAIL pc_wrap32: pc=%h instr=%h addr=%h expected 0/100/04",
                     if_id_pc, if_id_instr, imem_addr);
        end
    endtask

    task automatic test_disable();
        logic [31:0] s_cnt;
        set_in(1, 0, 1, 32'h4); tick();
        set_in(1, 0, 0, 0); tick();
        s_cnt = fetch_count;
        redirect = 1'b1; redirect_pc = 32'h4; tick(); redirect = 1'b0;
        fetch_en = 1'b0; tick(); tick();
        checks++;
        if ({if_id_valid, if_id_instr, imem_addr, fetch_count} !== {1'b0, NOP, 5'd4, s_cnt}) begin
            errors++;
            $display("FAIL disable: valid=%b instr=%h addr=%h cnt=%0d expected 0/13/04/%0d",
                     if_id_valid, if_id_instr, imem_addr, fetch_count, s_cnt);
        end
        fetch_en = 1'b1; tick();
        checks++;
        if ({if_id_valid, if_id_instr, if_id_pc, fetch_count} !== {1'b1, 32'h101, 32'd4, s_cnt + 32'd1}) begin
            errors++;
            $display("FAIL reenable: valid=%b instr=%h pc=%h cnt=%0d expected 1/101/4/%0d",
                     if_id_valid, if_id_instr, if_id_pc, fetch_count, s_cnt + 1);
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 1, 32'h10); tick();
        set_in(1, 0, 0, 0); tick(); tick();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h18;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr} !==
            {NOP, 32'd0, 1'b0, 32'd0, 5'd0}) begin
            errors++;
            $display("FAIL async_reset: instr=%h pc=%h valid=%b cnt=%0d addr=%h expected 13/0/0/0/00",
                     if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr);
        end
        model_reset();
        set_in(1, 0, 0, 0);
        tick();
        rst = 1'b0; tick();
        checks++;
        if ({if_id_pc, if_id_instr, if_id_valid, fetch_count} !== {32'd0, 32'h100, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL post_reset_fetch: pc=%h instr=%h valid=%b cnt=%0d expected 0/100/1/1",
                     if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 7) == 0, $urandom);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFFFFF0 | (redirect_pc & 32'hF);
            tick();
            checks++;
            if ({if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr} !==
                {m_instr, m_ipc, m_valid, m_cnt, m_pc[AB-1:0]}) begin
                errors++;
                $display("FAIL random[%0d]: instr=%h pc=%h valid=%b cnt=%0d addr=%h expected %h/%h/%b/%0d/%h",
                         i, if_id_instr, if_id_pc, if_id_valid, fetch_count, imem_addr,
                         m_instr, m_ipc, m_valid, m_cnt, m_pc[AB-1:0]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << AB) / 4; k++) mem[k] = 32'h100 + k;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_wrap();
        test_disable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
